// File: rtl/hazard_unit.sv
// Pipeline hazard controller: computes stall, flush and PC-enable controls for the
// 5-stage pipeline, plus a saturating stall-cycle counter and a data-wait watchdog.
module hazard_unit #(
    parameter int CNT_W     = 16,
    parameter int DWAIT_MAX = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      imemload_id,
    input  logic [31:0]      imemload_exe,
    input  logic             WEN_exe,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             branch_taken_exe,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             en_if_id,
    output logic             en_id_ex,
    output logic             en_ex_mem,
    output logic             en_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {RUN, DWAIT, LU_STALL, HALT} state_t;

    localparam int WC_W = $clog2(DWAIT_MAX + 1);

    state_t          state, next_state;
    logic [WC_W-1:0] wait_cnt;

    logic [6:0] opcode_id, opcode_exe;
    logic [4:0] rs1_id, rs2_id, rd_exe;
    logic       uses_rs1, uses_rs2, load_use, dfreeze;

    assign opcode_id  = imemload_id[6:0];
    assign opcode_exe = imemload_exe[6:0];
    assign rs1_id     = imemload_id[19:15];
    assign rs2_id     = imemload_id[24:20];
    assign rd_exe     = imemload_exe[11:7];

    assign uses_rs1 = !(opcode_id == 7'b0110111 || opcode_id == 7'b0010111 ||
                        opcode_id == 7'b1101111);
    assign uses_rs2 = (opcode_id == 7'b0110011 || opcode_id == 7'b0100011 ||
                       opcode_id == 7'b1100011);

    assign load_use = (opcode_exe == 7'b0000011) && WEN_exe && (rd_exe != 5'd0) &&
                      ((uses_rs1 && rs1_id == rd_exe) || (uses_rs2 && rs2_id == rd_exe));
    assign dfreeze  = (dREN_mem || dWEN_mem) && !dhit;

    assign halted = (state == HALT);

    always_comb begin
        pc_en       = 1'b1;
        en_if_id    = 1'b1;
        en_id_ex    = 1'b1;
        en_ex_mem   = 1'b1;
        en_mem_wb   = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        next_state  = RUN;
        if (state == HALT || halt_wb) begin
            {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
            next_state = HALT;
        end else if (dfreeze) begin
            // Freeze dominates a pending branch; it stays in EX until unfrozen.
            {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
            next_state = DWAIT;
        end else if (branch_taken_exe) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            en_if_id    = 1'b0;
            flush_id_ex = 1'b1;
            next_state  = LU_STALL;
        end else if (!ihit) begin
            pc_en       = 1'b0;
            flush_if_id = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            if (next_state == DWAIT) begin
                if (wait_cnt != WC_W'(DWAIT_MAX)) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= WC_W'(DWAIT_MAX - 1)) mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (!pc_en && state != HALT && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; one task per scenario, run with a
// 4-bit stall counter so saturation is reachable.
module tb_hazard_unit;
    localparam int CNT_W     = 4;
    localparam int DWAIT_MAX = 64;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] LW_X5   = 32'h0002_A283;
    localparam logic [31:0] LW_X0   = 32'h0002_A003;
    localparam logic [31:0] ADD_X5  = 32'h0012_8333;
    // ctl = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [6:0] C_RUN = 7'b1111100;
    localparam logic [6:0] C_LU  = 7'b0011101;
    localparam logic [6:0] C_FRZ = 7'b0000000;
    localparam logic [6:0] C_BR  = 7'b1111111;
    localparam logic [6:0] C_IM  = 7'b0111110;

    logic CLK = 1'b0, RST = 1'b1;
    logic [31:0] imemload_id = NOP, imemload_exe = NOP;
    logic WEN_exe = 1'b0, dREN_mem = 1'b0, dWEN_mem = 1'b0, dhit = 1'b0, ihit = 1'b1;
    logic branch_taken_exe = 1'b0, halt_wb = 1'b0;
    logic pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex;
    logic halted, mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [6:0] ctl;
    int errors = 0, checks = 0;

    assign ctl = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex};

    hazard_unit #(.CNT_W(CNT_W), .DWAIT_MAX(DWAIT_MAX)) dut (
        .CLK(CLK), .RST(RST), .imemload_id(imemload_id), .imemload_exe(imemload_exe),
        .WEN_exe(WEN_exe), .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dhit(dhit),
        .ihit(ihit), .branch_taken_exe(branch_taken_exe), .halt_wb(halt_wb),
        .pc_en(pc_en), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
        .en_mem_wb(en_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .halted(halted), .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        #1;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RUN); end
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
        checks++; if (halted !== 1'b0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", halted, mem_timeout); end
    endtask

    task automatic test_load_use();
        imemload_exe = LW_X5; imemload_id = ADD_X5; WEN_exe = 1'b1;
        #1;
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_stall got=%b exp=%b", ctl, C_LU); end
        tick();
        imemload_exe = NOP; WEN_exe = 1'b0;
        #1;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_release got=%b exp=%b", ctl, C_RUN); end
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
        tick();
        imemload_exe = LW_X0; WEN_exe = 1'b1;
        #1;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_rd0 got=%b exp=%b", ctl, C_RUN); end
        tick();
        imemload_exe = NOP; WEN_exe = 1'b0;
        #1;
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_rd0_count got=%0d exp=1", stall_count); end
    endtask

    task automatic test_dwait();
        dREN_mem = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL dwait_freeze[%0d] got=%b exp=%b", i, ctl, C_FRZ); end
            tick();
        end
        dhit = 1'b1;
        #1;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL dwait_release got=%b exp=%b", ctl, C_RUN); end
        tick();
        dREN_mem = 1'b0; dhit = 1'b0;
        #1;
        checks++; if (stall_count !== 4'd4) begin errors++; $display("FAIL dwait_count got=%0d exp=4", stall_count); end
    endtask

    task automatic test_branch_priority();
        imemload_exe = LW_X5; imemload_id = ADD_X5; WEN_exe = 1'b1;
        branch_taken_exe = 1'b1; ihit = 1'b0;
        #1;
        checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_prio got=%b exp=%b", ctl, C_BR); end
        tick();
        imemload_exe = NOP; WEN_exe = 1'b0; branch_taken_exe = 1'b0; ihit = 1'b1;
        #1;
        checks++; if (stall_count !== 4'd4) begin errors++; $display("FAIL br_no_stall got=%0d exp=4", stall_count); end
        ihit = 1'b0;
        #1;
        checks++; if (ctl !== C_IM) begin errors++; $display("FAIL imiss got=%b exp=%b", ctl, C_IM); end
        tick();
        ihit = 1'b1;
        #1;
        checks++; if (stall_count !== 4'd5) begin errors++; $display("FAIL imiss_count got=%0d exp=5", stall_count); end
    endtask

    task automatic test_timeout();
        dWEN_mem = 1'b1; dhit = 1'b0; branch_taken_exe = 1'b1;
        #1;
        checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL frz_over_br got=%b exp=%b", ctl, C_FRZ); end
        for (int i = 0; i < 63; i++) tick();
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", mem_timeout); end
        tick();
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got=%b exp=1", mem_timeout); end
        checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL timeout_frozen got=%b exp=%b", ctl, C_FRZ); end
        dhit = 1'b1;
        #1;
        checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_after_frz got=%b exp=%b", ctl, C_BR); end
        tick();
        dWEN_mem = 1'b0; dhit = 1'b0; branch_taken_exe = 1'b0;
        tick();
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", mem_timeout); end
        checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL stall_sat got=%0d exp=15", stall_count); end
    endtask

    task automatic test_halt();
        halt_wb = 1'b1;
        #1;
        checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL halt_now got=%b exp=%b", ctl, C_FRZ); end
        tick();
        halt_wb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            imemload_id = $urandom; imemload_exe = $urandom;
            {WEN_exe, dREN_mem, dWEN_mem, dhit, ihit, branch_taken_exe, halt_wb} = 7'($urandom);
            #1;
            checks++; if (ctl !== C_FRZ || halted !== 1'b1) begin errors++; $display("FAIL halt_hold[%0d] got=%b/%b exp=%b/1", i, ctl, halted, C_FRZ); end
            tick();
        end
        checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL halt_sat got=%0d exp=15", stall_count); end
        imemload_id = NOP; imemload_exe = NOP;
        {WEN_exe, dREN_mem, dWEN_mem, dhit, branch_taken_exe, halt_wb} = '0; ihit = 1'b1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++; if (ctl !== C_RUN || halted !== 1'b0) begin errors++; $display("FAIL halt_rst got=%b/%b exp=%b/0", ctl, halted, C_RUN); end
        checks++; if (mem_timeout !== 1'b0 || stall_count !== 4'd0) begin errors++; $display("FAIL halt_rst_cnt got=%b/%0d exp=0/0", mem_timeout, stall_count); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dwait();
        test_branch_priority();
        test_timeout();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
